// File: rtl/mult_sel_pipe_pkg.sv
// Select-field encodings and saturation bounds shared by the mult_sel_pipe block.
package mult_sel_pipe_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam int SEL_X_LSB = 0;
    localparam int SEL_X_MSB = 1;
    localparam int SEL_Y_LSB = 2;
    localparam int SEL_Y_MSB = 3;

    // Bounds of a signed (2w-1)-bit result; valid for w <= 32.
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (2 * w - 2)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (2 * w - 2));
    endfunction

endpackage

// File: rtl/mult_sel_pipe_stage.sv
// One valid/ready register slice; loads when empty or when its contents move on.
module mult_sel_pipe_stage
    import mult_sel_pipe_pkg::*;
#(
    parameter int DW       = 8,
    parameter bit RST_DATA = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld_i,
    output logic          rdy_o,
    input  logic [DW-1:0] dat_i,
    output logic          vld_o,
    input  logic          rdy_i,
    output logic [DW-1:0] dat_o
);

    logic          vld_q;
    logic [DW-1:0] dat_q;

    assign rdy_o = !vld_q || rdy_i;
    assign vld_o = vld_q;
    assign dat_o = dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else if (rdy_o) begin
            vld_q <= vld_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && RST_DATA) begin
            dat_q <= '0;
        end else if (rdy_o && vld_i) begin
            dat_q <= dat_i;
        end
    end

endmodule

// File: rtl/mult_sel_pipe.sv
// Pipelined operand-select multiplier with saturated (2W-1)-bit result and valid/ready flow.
// Optional accumulate path enabled by defining MULT_SEL_PIPE_ACC_EN.
module mult_sel_pipe
    import mult_sel_pipe_pkg::*;
#(
    parameter int W   = 16,
    parameter int LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    input  logic signed [W-1:0]   c,
    input  logic signed [W-1:0]   d,
    input  logic        [3:0]     sel,
`ifdef MULT_SEL_PIPE_ACC_EN
    input  logic                  in_acc,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*W-2:0] y,
    output logic                  y_sat
);

    localparam int PW = 2 * W;
    localparam int RW = 2 * W - 1;
    localparam int CW = PW + 1;
    localparam int NC = (LAT > 1) ? LAT - 1 : 1;
    localparam logic signed [RW-1:0] Y_MAX = RW'(sat_max(W));
    localparam logic signed [RW-1:0] Y_MIN = RW'(sat_min(W));

    function automatic logic signed [W-1:0] pick(input logic [1:0] code,
        input logic signed [W-1:0] oa, input logic signed [W-1:0] ob,
        input logic signed [W-1:0] oc, input logic signed [W-1:0] od);
        logic signed [W-1:0] r;
        r = od;
        case (code)
            SEL_A: r = oa;
            SEL_B: r = ob;
            SEL_C: r = oc;
            SEL_D: r = od;
        endcase
        return r;
    endfunction

    // Returns {saturated, value}; a 2W-bit value overflows when its top two bits differ.
    function automatic logic [RW:0] clamp(input logic [PW-1:0] v);
        logic [RW:0] r;
        r = {1'b0, v[RW-1:0]};
        if (v[PW-1] != v[PW-2]) r = {1'b1, v[PW-1] ? Y_MIN : Y_MAX};
        return r;
    endfunction

    function automatic logic [RW:0] finalize(input logic [PW-1:0] p, input logic use_acc,
        input logic [RW-1:0] acc);
        logic [RW:0] pc, sc;
        pc = clamp(p);
        sc = clamp({pc[RW-1], pc[RW-1:0]} + {acc[RW-1], acc});
        return use_acc ? {pc[RW] | sc[RW], sc[RW-1:0]} : pc;
    endfunction

    logic                    acc_in;
    logic [RW-1:0]           acc_val;
    logic signed [W-1:0]     opx_sel, opy_sel;
    logic [NC-1:0]           chain_vld, chain_rdy;
    logic [NC-1:0][CW-1:0]   chain_dat;
    logic [PW-1:0]           fin_d, fin_q;

    assign opx_sel = pick(sel[SEL_X_MSB:SEL_X_LSB], a, b, c, d);
    assign opy_sel = pick(sel[SEL_Y_MSB:SEL_Y_LSB], a, b, c, d);

    // Stage 1: selected operands (or, for a single-stage build, the product feeds the output stage)
    if (LAT == 1) begin : g_front_comb
        logic signed [PW-1:0] prod;
        assign prod         = PW'(opx_sel) * PW'(opy_sel);
        assign chain_vld[0] = in_valid;
        assign chain_dat[0] = {acc_in, prod};
        assign in_ready     = chain_rdy[0];
    end else begin : g_front_reg
        logic signed [W-1:0]  opx_p1_q, opy_p1_q;
        logic                 acc_p1_q, vld_p1_q;
        logic signed [PW-1:0] prod_p1;

        assign in_ready = !vld_p1_q || chain_rdy[0];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p1_q <= 1'b0;
            end else if (in_ready) begin
                vld_p1_q <= in_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (in_valid && in_ready) begin
                opx_p1_q <= opx_sel;
                opy_p1_q <= opy_sel;
                acc_p1_q <= acc_in;
            end
        end

        assign prod_p1      = PW'(opx_p1_q) * PW'(opy_p1_q);
        assign chain_vld[0] = vld_p1_q;
        assign chain_dat[0] = {acc_p1_q, prod_p1};
    end

    // Stages 2..LAT-1: carry the full product and its accumulate flag
    for (genvar k = 1; k < NC; k++) begin : g_mid
        mult_sel_pipe_stage #(.DW(CW), .RST_DATA(1'b0)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .vld_i (chain_vld[k-1]),
            .rdy_o (chain_rdy[k-1]),
            .dat_i (chain_dat[k-1]),
            .vld_o (chain_vld[k]),
            .rdy_i (chain_rdy[k]),
            .dat_o (chain_dat[k])
        );
    end

    // Final stage: saturate (and optionally accumulate) as the result is loaded
    assign fin_d = finalize(chain_dat[NC-1][PW-1:0], chain_dat[NC-1][PW], acc_val);

    mult_sel_pipe_stage #(.DW(PW), .RST_DATA(1'b1)) u_out (
        .clk   (clk),
        .rst   (rst),
        .vld_i (chain_vld[NC-1]),
        .rdy_o (chain_rdy[NC-1]),
        .dat_i (fin_d),
        .vld_o (out_valid),
        .rdy_i (out_ready),
        .dat_o (fin_q)
    );

    assign {y_sat, y} = fin_q;

`ifdef MULT_SEL_PIPE_ACC_EN
    logic [RW-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (chain_vld[NC-1] && chain_rdy[NC-1]) begin
            acc_q <= fin_d[RW-1:0];
        end
    end

    assign acc_in  = in_acc;
    assign acc_val = acc_q;
`else
    assign acc_in  = 1'b0;
    assign acc_val = '0;
`endif

endmodule

// File: tb/tb_mult_sel_pipe.sv
// Bench for mult_sel_pipe: directed corner cases plus randomized traffic against an arithmetic model.
module tb_mult_sel_pipe;

    localparam int W   = 16;
    localparam int LAT = 3;
    localparam int RW  = 2 * W - 1;
    localparam longint MAXV = (64'sd1 <<< (2 * W - 2)) - 1;
    localparam longint MINV = -(64'sd1 <<< (2 * W - 2));

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_acc = 1'b0;
    logic signed [W-1:0]  a = '0, b = '0, c = '0, d = '0;
    logic        [3:0]    sel = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [RW-1:0] y;
    logic                 y_sat;

    int          pass_cnt = 0;
    int          check_cnt = 0;
    longint      m_acc = 0;
    logic [RW:0] exp_q[$];

    always #5 clk = ~clk;

    mult_sel_pipe #(.W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .sel       (sel),
`ifdef MULT_SEL_PIPE_ACC_EN
        .in_acc    (in_acc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_sat     (y_sat)
    );

    // Reference: pick operands by index, multiply as integers, clamp to the result range.
    function automatic logic [RW:0] model(input logic [3:0] s, input logic acc_req);
        longint ops[4];
        longint p;
        logic   sat;
        ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
        p = ops[s[1:0]] * ops[s[3:2]];
        sat = 1'b0;
        if (p > MAXV) begin p = MAXV; sat = 1'b1; end
        if (acc_req) begin
            p = p + m_acc;
            if (p > MAXV) begin p = MAXV; sat = 1'b1; end
            else if (p < MINV) begin p = MINV; sat = 1'b1; end
        end
        m_acc = p;
        return {sat, p[RW-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] r;
        case ($urandom_range(0, 5))
            0: r = {1'b1, {(W-1){1'b0}}};
            1: r = {1'b0, {(W-1){1'b1}}};
            2: r = '0;
            3: r = '1;
            default: r = W'($urandom);
        endcase
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_acc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_acc = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        a = 16'h1234; b = 16'h8000; sel = 4'b0101;
        do_reset();
        #1;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (y !== '0) $display("FAIL reset_y: got %h expected 0", y);
        else pass_cnt++;
        check_cnt++;
        if (y_sat !== 1'b0) $display("FAIL reset_y_sat: got %b expected 0", y_sat);
        else pass_cnt++;
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [W-1:0]  ta[4]   = '{16'h0003, 16'h0000, 16'h8000, 16'h00B5};
        logic [W-1:0]  tb[4]   = '{16'h0005, 16'h0000, 16'h8000, 16'h0000};
        logic [W-1:0]  tc[4]   = '{16'h0000, 16'h0007, 16'h0000, 16'h0000};
        logic [W-1:0]  td[4]   = '{16'h0000, 16'hFFFE, 16'h0000, 16'h0000};
        logic [3:0]    ts[4]   = '{4'b0100, 4'b1011, 4'b0100, 4'b0000};
        logic [RW-1:0] ty[4]   = '{31'd15, 31'h7FFFFFF2, 31'h3FFFFFFF, 31'd32761};
        logic          tsat[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            a = ta[i]; b = tb[i]; c = tc[i]; d = td[i]; sel = ts[i];
            #1;
            check_cnt++;
            if (in_ready !== 1'b1) $display("FAIL dir_in_ready[%0d]: got %b expected 1", i, in_ready);
            else pass_cnt++;
            @(negedge clk);
            in_valid = 1'b0;
            n = 1;
            #1;
            while (out_valid !== 1'b1 && n < 12) begin
                @(negedge clk);
                n++;
                #1;
            end
            check_cnt++;
            if (n != LAT) $display("FAIL dir_latency[%0d]: got %0d edges expected %0d", i, n, LAT);
            else pass_cnt++;
            check_cnt++;
            if (y !== ty[i]) $display("FAIL dir_y[%0d]: got %h expected %h", i, y, ty[i]);
            else pass_cnt++;
            check_cnt++;
            if (y_sat !== tsat[i]) $display("FAIL dir_y_sat[%0d]: got %b expected %b", i, y_sat, tsat[i]);
            else pass_cnt++;
            @(negedge clk);
            #1;
            check_cnt++;
            if (out_valid !== 1'b0) $display("FAIL dir_no_dup[%0d]: out_valid got %b expected 0", i, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int          sent, got, first_c, last_c;
        logic        last_rdy, prev_stall;
        logic [RW:0] held, exp;
        do_reset();
        sent = 0; got = 0; first_c = -1; last_c = -1;
        prev_stall = 1'b0; held = '0; last_rdy = 1'b1;
        for (int t = 0; t < 8; t++) begin
            out_ready = 1'b0;
            in_valid = (sent < 6);
            a = rnd_op(); b = rnd_op(); c = rnd_op(); d = rnd_op(); sel = 4'($urandom);
            #1;
            last_rdy = in_ready;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(sel, 1'b0));
                sent++;
            end
            if (prev_stall) begin
                check_cnt++;
                if (out_valid !== 1'b1 || {y_sat, y} !== held)
                    $display("FAIL bp_hold: got valid %b y %h, required 1 and %h", out_valid, {y_sat, y}, held);
                else pass_cnt++;
            end
            prev_stall = (out_valid === 1'b1);
            held = {y_sat, y};
            @(negedge clk);
        end
        check_cnt++;
        if (sent != 3) $display("FAIL bp_accepted: got %0d expected 3", sent);
        else pass_cnt++;
        check_cnt++;
        if (last_rdy !== 1'b0) $display("FAIL bp_in_ready_low: got %b expected 0", last_rdy);
        else pass_cnt++;
        if (exp_q.size() > 0) begin
            check_cnt++;
            if ({y_sat, y} !== exp_q[0]) $display("FAIL bp_stalled_y: got %h expected %h", {y_sat, y}, exp_q[0]);
            else pass_cnt++;
        end
        for (int t = 0; t < 30 && got < 6; t++) begin
            out_ready = 1'b1;
            in_valid = (sent < 6);
            a = rnd_op(); b = rnd_op(); c = rnd_op(); d = rnd_op(); sel = 4'($urandom);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(sel, 1'b0));
                sent++;
            end
            if (out_valid === 1'b1) begin
                check_cnt++;
                if (exp_q.size() == 0) $display("FAIL bp_extra: got %h with nothing expected", {y_sat, y});
                else begin
                    exp = exp_q.pop_front();
                    if ({y_sat, y} !== exp) $display("FAIL bp_order[%0d]: got %h expected %h", got, {y_sat, y}, exp);
                    else pass_cnt++;
                end
                got++;
                if (first_c < 0) first_c = t;
                last_c = t;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_cnt++;
        if (got != 6) $display("FAIL bp_count: got %0d results expected 6", got);
        else pass_cnt++;
        check_cnt++;
        if (last_c - first_c != 5) $display("FAIL bp_throughput: got span %0d expected 5", last_c - first_c);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = rnd_op(); b = rnd_op(); sel = 4'b0100;
            @(negedge clk);
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (y !== '0 || y_sat !== 1'b0) $display("FAIL rmid_y: got %h/%b expected 0/0", y, y_sat);
        else pass_cnt++;
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b1; a = 16'hFFF9; b = 16'h0009; sel = 4'b0100;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        #1;
        while (out_valid !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
            #1;
        end
        check_cnt++;
        if (n != LAT) $display("FAIL rmid_latency: got %0d edges expected %0d", n, LAT);
        else pass_cnt++;
        check_cnt++;
        if (y !== 31'h7FFFFFC1 || y_sat !== 1'b0) $display("FAIL rmid_result: got %h/%b expected 7fffffc1/0", y, y_sat);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic        prev_stall;
        logic [RW:0] held, exp;
        do_reset();
        prev_stall = 1'b0; held = '0;
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a = rnd_op(); b = rnd_op(); c = rnd_op(); d = rnd_op(); sel = 4'($urandom);
`ifdef MULT_SEL_PIPE_ACC_EN
            in_acc = 1'($urandom_range(0, 1));
`endif
            #1;
            if (in_valid && in_ready) exp_q.push_back(model(sel, in_acc));
            if (prev_stall) begin
                check_cnt++;
                if (out_valid !== 1'b1 || {y_sat, y} !== held)
                    $display("FAIL rand_hold[%0d]: got valid %b y %h, required 1 and %h", t, out_valid, {y_sat, y}, held);
                else pass_cnt++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                check_cnt++;
                if (exp_q.size() == 0) $display("FAIL rand_extra[%0d]: got %h with nothing expected", t, {y_sat, y});
                else begin
                    exp = exp_q.pop_front();
                    if ({y_sat, y} !== exp) $display("FAIL rand_y[%0d]: got %h expected %h", t, {y_sat, y}, exp);
                    else pass_cnt++;
                end
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            held = {y_sat, y};
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1; in_acc = 1'b0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (out_valid === 1'b1) begin
                check_cnt++;
                if (exp_q.size() == 0) $display("FAIL drain_extra: got %h with nothing expected", {y_sat, y});
                else begin
                    exp = exp_q.pop_front();
                    if ({y_sat, y} !== exp) $display("FAIL drain_y: got %h expected %h", {y_sat, y}, exp);
                    else pass_cnt++;
                end
            end
            @(negedge clk);
        end
        check_cnt++;
        if (exp_q.size() != 0) $display("FAIL rand_lost: got %0d outstanding expected 0", exp_q.size());
        else pass_cnt++;
    endtask

`ifdef MULT_SEL_PIPE_ACC_EN
    task automatic test_acc();
        logic [W-1:0]  ta[6]   = '{16'd10, 16'd23, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000};
        logic [W-1:0]  tb[6]   = '{16'd10, 16'd1,  16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        logic          tacc[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [RW-1:0] ty[6]   = '{31'd100, 31'd123, 31'h3FFFFFFF, 31'h3FFFFFFF, 31'h40008000, 31'h40000000};
        logic          tsat[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int n;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_acc = tacc[i];
            a = ta[i]; b = tb[i]; sel = 4'b0100;
            @(negedge clk);
            in_valid = 1'b0; in_acc = 1'b0;
            n = 1;
            #1;
            while (out_valid !== 1'b1 && n < 12) begin
                @(negedge clk);
                n++;
                #1;
            end
            check_cnt++;
            if (y !== ty[i]) $display("FAIL acc_y[%0d]: got %h expected %h", i, y, ty[i]);
            else pass_cnt++;
            check_cnt++;
            if (y_sat !== tsat[i]) $display("FAIL acc_y_sat[%0d]: got %b expected %b", i, y_sat, tsat[i]);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef MULT_SEL_PIPE_ACC_EN
        test_acc();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
